// File: rtl/vx_fill_assembler_pkg.sv
// ---------------------------------------------------------------------------
// VX_cache_pkg
// Shared cache definitions used by the fill assembler and the writeback path.
//   fill_state_e : fill assembler FSM states
//   calc_beats   : number of memory beats that make up one cache line
//   calc_cnt_w   : width of a beat counter for a given beat count (min 1)
// ---------------------------------------------------------------------------
package VX_cache_pkg;

  typedef enum logic [1:0] {
    FILL_IDLE    = 2'd0,
    FILL_COLLECT = 2'd1,
    FILL_ISSUE   = 2'd2
  } fill_state_e;

  // Beats per line; both sizes are powers of two so the division is exact.
  function automatic int calc_beats(input int lineSize, input int memSize);
    return lineSize / memSize;
  endfunction

  // A single-beat line still needs a 1-bit counter so the port/array
  // declarations never collapse to zero width.
  function automatic int calc_cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/vx_fill_assembler.sv
// ---------------------------------------------------------------------------
// vx_fill_assembler
// Collects narrow memory response beats for one cache bank into a full line
// buffer and presents the assembled line plus its address as one fill request.
//
// Ports
//   clk_i / reset_i     clock, synchronous active-high reset
//   mem_rsp_valid_i     response beat valid
//   mem_rsp_data_i      beat payload (MEM_DATA_SIZE*8 bits)
//   mem_rsp_addr_i      line address of the beat
//   mem_rsp_last_i      final beat of the line
//   mem_rsp_ready_o     beat accepted when valid & ready
//   fill_valid_o        assembled line available
//   fill_addr_o         line address of the fill
//   fill_data_o         assembled line, beat i at [i*BEAT_W +: BEAT_W]
//   fill_ready_i        bank pipeline takes the fill when valid & ready
//   busy_o              FSM not idle
//   err_o               sticky protocol error
//
// Build option
//   VX_FILL_ASSEMBLER_CHECK_EN : when defined, err_o flags beats whose
//   address differs from the line address, or whose last flag does not match
//   the beat position. When undefined, mem_rsp_last_i is ignored and err_o
//   is tied low.
// ---------------------------------------------------------------------------
module vx_fill_assembler
  import VX_cache_pkg::*;
#(
  parameter int CACHE_LINE_SIZE = 64,
  parameter int MEM_DATA_SIZE   = 16,
  parameter int LINE_ADDR_WIDTH = 26
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         mem_rsp_valid_i,
  input  logic [MEM_DATA_SIZE*8-1:0]   mem_rsp_data_i,
  input  logic [LINE_ADDR_WIDTH-1:0]   mem_rsp_addr_i,
  input  logic                         mem_rsp_last_i,
  output logic                         mem_rsp_ready_o,
  output logic                         fill_valid_o,
  output logic [LINE_ADDR_WIDTH-1:0]   fill_addr_o,
  output logic [CACHE_LINE_SIZE*8-1:0] fill_data_o,
  input  logic                         fill_ready_i,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int BEATS  = calc_beats(CACHE_LINE_SIZE, MEM_DATA_SIZE);
  localparam int CNT_W  = calc_cnt_w(BEATS);
  localparam int BEAT_W = MEM_DATA_SIZE * 8;

  fill_state_e state_q, state_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [LINE_ADDR_WIDTH-1:0] fill_addr_q;
  logic [BEATS-1:0][BEAT_W-1:0] line_q;

  logic beatAccept;
  logic firstBeat;
  logic lastSlot;

  // Any beat taken outside COLLECT starts a new line: in IDLE trivially, and
  // in ISSUE it can only be accepted together with the outgoing fill.
  assign beatAccept = mem_rsp_valid_i & mem_rsp_ready_o;
  assign firstBeat  = (state_q != FILL_COLLECT);
  assign lastSlot   = (count_q == CNT_W'(BEATS - 1));

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= FILL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; lastSlot is already true on the first beat when a line
  // is a single beat, so IDLE/ISSUE go straight back to ISSUE in that case.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL_IDLE: begin
        if (beatAccept) state_d = lastSlot ? FILL_ISSUE : FILL_COLLECT;
      end
      FILL_COLLECT: begin
        if (beatAccept && lastSlot) state_d = FILL_ISSUE;
      end
      FILL_ISSUE: begin
        if (fill_ready_i) begin
          if (!beatAccept)   state_d = FILL_IDLE;
          else if (lastSlot) state_d = FILL_ISSUE;
          else               state_d = FILL_COLLECT;
        end
      end
      default: state_d = FILL_IDLE;
    endcase
  end

  // Outputs; ready is a pure function of state and fill_ready so the memory
  // side never sees a valid->ready combinational path.
  always_comb begin
    mem_rsp_ready_o = (state_q != FILL_ISSUE) | fill_ready_i;
    fill_valid_o    = (state_q == FILL_ISSUE);
    busy_o          = (state_q != FILL_IDLE);
  end

  // Beat counter wraps after the last slot, so it is back at 0 in ISSUE
  // ready for a first beat accepted alongside the fill handshake.
  always_comb begin
    count_d = count_q;
    if (beatAccept) count_d = lastSlot ? '0 : count_q + CNT_W'(1);
  end

  // Line buffer and address capture. In ISSUE nothing is written unless the
  // fill is taken in the same cycle, which keeps the fill payload stable.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q     <= '0;
      fill_addr_q <= '0;
      line_q      <= '0;
    end else begin
      count_q <= count_d;
      if (beatAccept && firstBeat) fill_addr_q <= mem_rsp_addr_i;
      for (int i = 0; i < BEATS; i++) begin
        if (beatAccept && (count_q == CNT_W'(i))) line_q[i] <= mem_rsp_data_i;
      end
    end
  end

  assign fill_addr_o = fill_addr_q;
  assign fill_data_o = line_q;

`ifdef VX_FILL_ASSEMBLER_CHECK_EN
  logic err_q;
  logic errSet;

  // Flag address drift within a line and a last flag out of step with the
  // beat position; the beat itself is still assembled.
  assign errSet = beatAccept &
                  ((!firstBeat && (mem_rsp_addr_i != fill_addr_q)) |
                   (mem_rsp_last_i != lastSlot));

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      err_q <= 1'b0;
    end else if (errSet) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic unusedLast;

  assign unusedLast = mem_rsp_last_i;
  assign err_o      = 1'b0;
`endif

endmodule
